// File: rtl/dbgcmd_pkg.sv
// Debug command sequencer types: opcodes, state encodings, step descriptor, step-list builder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dbgcmd_pkg;

  // Debug slave register offsets
  localparam logic [11:0] DBG_EN         = 12'h000;
  localparam logic [11:0] DBGAPB_INST    = 12'h004;
  localparam logic [11:0] DBGAPB_INST_WR = 12'h008;
  localparam logic [11:0] DBGAPB_WDATA_L = 12'h00C;
  localparam logic [11:0] DBGAPB_WDATA_H = 12'h010;
  localparam logic [11:0] DBGAPB_WDATA_WR= 12'h014;
  localparam logic [11:0] DBGAPB_RDATA_L = 12'h018;
  localparam logic [11:0] DBGAPB_RDATA_H = 12'h01C;

  // Debug instruction codes (low 12 bits of the instruction word)
  localparam logic [11:0] INST_ATTACH     = 12'h001;
  localparam logic [11:0] INST_RESUME     = 12'h002;
  localparam logic [11:0] INST_STATUS_RD  = 12'h003;
  localparam logic [11:0] INST_PC_RD      = 12'h004;
  localparam logic [11:0] INST_GPR_RD     = 12'h005;
  localparam logic [11:0] INST_CSR_RD     = 12'h006;
  localparam logic [11:0] INST_GPR_WR     = 12'h007;
  localparam logic [11:0] INST_CSR_WR     = 12'h008;
  localparam logic [11:0] INST_INSTREG_WR = 12'h009;
  localparam logic [11:0] INST_EXECUTE    = 12'h00A;

  typedef enum logic [3:0] {
    OP_EN        = 4'd0,
    OP_DIS       = 4'd1,
    OP_ATTACH    = 4'd2,
    OP_RESUME    = 4'd3,
    OP_STATUS_RD = 4'd4,
    OP_PC_RD     = 4'd5,
    OP_GPR_RD    = 4'd6,
    OP_CSR_RD    = 4'd7,
    OP_GPR_WR    = 4'd8,
    OP_CSR_WR    = 4'd9,
    OP_EXEC      = 4'd10
  } op_e;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_RESP} top_st_e;

  // XF_SETUP doubles as idle: the SETUP phase is this state with req high.
  typedef enum logic {XF_SETUP, XF_ACCESS} xfer_st_e;

  typedef struct packed {
    logic        write;
    logic [11:0] offset;
    logic [31:0] data;
  } step_t;

  function automatic step_t wr_step(input logic [11:0] off, input logic [31:0] d);
    return '{write: 1'b1, offset: off, data: d};
  endfunction

  function automatic step_t rd_step(input logic [11:0] off);
    return '{write: 1'b0, offset: off, data: 32'h0};
  endfunction

  function automatic logic [31:0] inst_word(input logic [11:0] addr, input logic [11:0] code);
    return {4'h0, addr, 4'h0, code};
  endfunction

  // Number of APB transfers an opcode expands to; 0 marks an illegal opcode.
  function automatic logic [3:0] step_count(input logic [3:0] op, input logic x64);
    case (op)
      OP_EN, OP_DIS:                                    return 4'd1;
      OP_ATTACH, OP_RESUME:                             return 4'd2;
      OP_STATUS_RD, OP_PC_RD, OP_GPR_RD, OP_CSR_RD:     return x64 ? 4'd4 : 4'd3;
      OP_GPR_WR, OP_CSR_WR:                             return x64 ? 4'd5 : 4'd4;
      OP_EXEC:                                          return 4'd6;
      default:                                          return 4'd0;
    endcase
  endfunction

  // Step idx of the list for op. Write lists are laid out in 64-bit form;
  // at 32 bits the WDATA_H slot is skipped by remapping the index.
  function automatic step_t get_step(input logic [3:0] op, input logic [3:0] idx,
                                     input logic [11:0] addr, input logic [63:0] wd,
                                     input logic x64);
    step_t       s;
    logic [3:0]  j;
    logic [11:0] code;
    s    = '0;
    j    = idx;
    code = '0;
    case (op)
      OP_EN:  s = wr_step(DBG_EN, 32'd1);
      OP_DIS: s = wr_step(DBG_EN, 32'd0);
      OP_ATTACH, OP_RESUME: begin
        code = (op == OP_ATTACH) ? INST_ATTACH : INST_RESUME;
        s = (idx == 4'd0) ? wr_step(DBGAPB_INST, inst_word(addr, code))
                          : wr_step(DBGAPB_INST_WR, 32'd1);
      end
      OP_STATUS_RD, OP_PC_RD, OP_GPR_RD, OP_CSR_RD: begin
        case (op)
          OP_STATUS_RD: code = INST_STATUS_RD;
          OP_PC_RD:     code = INST_PC_RD;
          OP_GPR_RD:    code = INST_GPR_RD;
          default:      code = INST_CSR_RD;
        endcase
        case (idx)
          4'd0:    s = wr_step(DBGAPB_INST, inst_word(addr, code));
          4'd1:    s = wr_step(DBGAPB_INST_WR, 32'd1);
          4'd2:    s = rd_step(DBGAPB_RDATA_L);
          default: s = rd_step(DBGAPB_RDATA_H);
        endcase
      end
      OP_GPR_WR, OP_CSR_WR: begin
        code = (op == OP_GPR_WR) ? INST_GPR_WR : INST_CSR_WR;
        if (!x64 && idx != 4'd0) j = idx + 4'd1;
        case (j)
          4'd0:    s = wr_step(DBGAPB_WDATA_L, wd[31:0]);
          4'd1:    s = wr_step(DBGAPB_WDATA_H, wd[63:32]);
          4'd2:    s = wr_step(DBGAPB_WDATA_WR, 32'd1);
          4'd3:    s = wr_step(DBGAPB_INST, inst_word(addr, code));
          default: s = wr_step(DBGAPB_INST_WR, 32'd1);
        endcase
      end
      OP_EXEC: begin
        case (idx)
          4'd0:    s = wr_step(DBGAPB_WDATA_L, wd[31:0]);
          4'd1:    s = wr_step(DBGAPB_WDATA_WR, 32'd1);
          4'd2:    s = wr_step(DBGAPB_INST, inst_word(addr, INST_INSTREG_WR));
          4'd3:    s = wr_step(DBGAPB_INST_WR, 32'd1);
          4'd4:    s = wr_step(DBGAPB_INST, inst_word(addr, INST_EXECUTE));
          default: s = wr_step(DBGAPB_INST_WR, 32'd1);
        endcase
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dbgcmd_if.sv
// Command, response and APB bundle between the debug sequencer and its environment.
// Latency: n/a (wiring only).
// Backpressure: cmd valid/ready, rsp valid/ready, APB pready wait states.
interface dbgcmd_if #(parameter int XLEN = 32);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_op;
  logic [11:0]     cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [31:0]     paddr;
  logic [3:0]      pstrb;
  logic [31:0]     pwdata;
  logic [31:0]     prdata;
  logic            pready;
  logic            pslverr;

  // Sequencer side: accepts commands, returns responses, masters the APB.
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pstrb, pwdata
  );

  // Environment side: issues commands, consumes responses, acts as the APB slave.
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pstrb, pwdata
  );
endinterface

// File: rtl/dbgcmd_apb_mst.sv
// Single-transfer APB master with wait-state timeout.
// Latency: SETUP in the cycle req is seen, ACCESS from the next cycle; done on the completing ACCESS.
// Backpressure: holds ACCESS while pready=0; aborts with err after TIMEOUT wait cycles.
import dbgcmd_pkg::*;

module dbgcmd_apb_mst #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [3:0]  pstrb,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  xfer_st_e   xst, xst_nxt;
  logic [9:0] wcnt, wcnt_nxt;
  logic       sel, en;

  // Transfer state and wait counter registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      xst  <= XF_SETUP;
      wcnt <= '0;
    end else begin
      xst  <= xst_nxt;
      wcnt <= wcnt_nxt;
    end
  end

  // SETUP/ACCESS sequencing, completion and timeout detection.
  always_comb begin
    xst_nxt  = xst;
    wcnt_nxt = wcnt;
    done     = 1'b0;
    err      = 1'b0;
    sel      = 1'b0;
    en       = 1'b0;
    case (xst)
      XF_SETUP: begin
        wcnt_nxt = '0;
        if (req) begin
          sel     = 1'b1;
          xst_nxt = XF_ACCESS;
        end
      end
      XF_ACCESS: begin
        sel = 1'b1;
        en  = 1'b1;
        if (pready) begin
          done    = 1'b1;
          err     = pslverr;
          xst_nxt = XF_SETUP;
        end else if ({1'b0, wcnt} + 11'd1 == 11'(TIMEOUT)) begin
          done    = 1'b1;
          err     = 1'b1;
          xst_nxt = XF_SETUP;
        end else begin
          wcnt_nxt = wcnt + 10'd1;
        end
      end
      default: xst_nxt = XF_SETUP;
    endcase
  end

  assign psel    = sel;
  assign penable = en;
  assign pwrite  = sel & write;
  assign paddr   = sel ? addr : 32'h0;
  assign pstrb   = (sel & write) ? 4'hf : 4'h0;
  assign pwdata  = (sel & write) ? wdata : 32'h0;
  assign rdata   = prdata;

endmodule

// File: rtl/dbgcmd_seq.sv
// Expands one debug command into its fixed APB step list and returns a held response.
// Latency: first SETUP the cycle after accept; rsp_valid the cycle after the final ACCESS.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready.
import dbgcmd_pkg::*;

module dbgcmd_seq #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic     pclk,
  input  logic     preset,
  dbgcmd_if.master bus
);

  localparam logic X64 = (XLEN == 64);

  top_st_e         st, st_nxt;
  logic [3:0]      op_q;
  logic [11:0]     addr_q;
  logic [63:0]     wdata_q;
  logic [3:0]      step_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  step_t           cur;
  logic [3:0]      n_steps;
  logic [3:0]      acc_cnt;
  logic            accept;
  logic            done, xerr;
  logic [31:0]     xrdata;

  assign cur     = get_step(op_q, step_q, addr_q, wdata_q, X64);
  assign n_steps = step_count(op_q, X64);
  assign acc_cnt = step_count(bus.cmd_op, X64);
  assign accept  = (st == T_IDLE) && bus.cmd_valid;

  dbgcmd_apb_mst #(.TIMEOUT(TIMEOUT)) u_mst (
    .pclk    (pclk),
    .preset  (preset),
    .req     (st == T_RUN),
    .write   (cur.write),
    .addr    (BASE_ADDR + {20'h0, cur.offset}),
    .wdata   (cur.data),
    .done    (done),
    .rdata   (xrdata),
    .err     (xerr),
    .psel    (bus.psel),
    .penable (bus.penable),
    .pwrite  (bus.pwrite),
    .paddr   (bus.paddr),
    .pstrb   (bus.pstrb),
    .pwdata  (bus.pwdata),
    .prdata  (bus.prdata),
    .pready  (bus.pready),
    .pslverr (bus.pslverr)
  );

  // Command state register.
  always_ff @(posedge pclk) begin
    if (preset) st <= T_IDLE;
    else        st <= st_nxt;
  end

  // Command state transitions; illegal opcodes go straight to the response.
  always_comb begin
    st_nxt = st;
    case (st)
      T_IDLE: if (bus.cmd_valid) st_nxt = (acc_cnt == 4'd0) ? T_RESP : T_RUN;
      T_RUN:  if (done && (xerr || step_q == n_steps - 4'd1)) st_nxt = T_RESP;
      T_RESP: if (bus.rsp_ready) st_nxt = T_IDLE;
      default: st_nxt = T_IDLE;
    endcase
  end

  // Command latch, step counter and response capture.
  always_ff @(posedge pclk) begin
    if (preset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      step_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.cmd_op;
      addr_q  <= bus.cmd_addr;
      wdata_q <= 64'(bus.cmd_wdata);
      step_q  <= '0;
      rdata_q <= '0;
      err_q   <= (acc_cnt == 4'd0);
    end else if (st == T_RUN && done) begin
      if (xerr) begin
        err_q <= 1'b1;
      end else begin
        if (!cur.write) begin
          if (X64 && cur.offset == DBGAPB_RDATA_H) rdata_q[XLEN-1 -: 32] <= xrdata;
          else                                      rdata_q[31:0]        <= xrdata;
        end
        step_q <= step_q + 4'd1;
      end
    end
  end

  assign bus.cmd_ready = (st == T_IDLE);
  assign bus.rsp_valid = (st == T_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dbgcmd_seq.sv
// Randomized and directed bench for dbgcmd_seq against a transfer-list reference model.
// Latency: n/a (testbench).
// Backpressure: slave model inserts planned wait states; response acceptance delayed per command.
module tb_dbgcmd_seq;

  localparam int          XLEN    = 32;
  localparam int          TMO     = 1023;
  localparam logic [31:0] BASE    = 32'h4000_0000;

  localparam logic [11:0] R_EN = 12'h000, R_INST = 12'h004, R_INSTWR = 12'h008;
  localparam logic [11:0] R_WDL = 12'h00C, R_WDWR = 12'h014, R_RDL = 12'h018;
  localparam logic [11:0] C_ATT = 12'h001, C_RES = 12'h002, C_STAT = 12'h003, C_PC = 12'h004;
  localparam logic [11:0] C_GRD = 12'h005, C_CRD = 12'h006, C_GWR = 12'h007, C_CWR = 12'h008;
  localparam logic [11:0] C_IREG = 12'h009, C_EXE = 12'h00A;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  strb;
  } xfer_t;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  dbgcmd_if #(.XLEN(XLEN)) bus ();

  dbgcmd_seq #(.XLEN(XLEN), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  xfer_t       obs_q[$];
  xfer_t       exp_q[$];
  int          waits[16];
  bit          serr[16];
  logic [31:0] rdat[16];
  int          proto_viol = 0;
  bit          prev_setup = 1'b0;
  int          wcnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // APB slave: per-transfer plan indexed by number of completed transfers.
  always @(negedge pclk) begin
    int k;
    if (prev_setup && !(bus.psel && bus.penable)) proto_viol++;
    prev_setup = bus.psel && !bus.penable;
    if (bus.psel && !bus.penable) wcnt = 0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = $urandom;
    if (bus.psel && bus.penable) begin
      k = (obs_q.size() < 16) ? obs_q.size() : 15;
      if (wcnt < waits[k]) begin
        wcnt++;
      end else begin
        bus.pready  = 1'b1;
        bus.pslverr = serr[k];
        bus.prdata  = rdat[k];
        obs_q.push_back('{bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb});
      end
    end
  end

  task automatic push_w(input logic [11:0] off, input logic [31:0] d);
    exp_q.push_back('{BASE + {20'h0, off}, 1'b1, d, 4'hf});
  endtask

  task automatic push_r(input logic [11:0] off);
    exp_q.push_back('{BASE + {20'h0, off}, 1'b0, 32'h0, 4'h0});
  endtask

  task automatic push_inst(input logic [11:0] a, input logic [11:0] c);
    push_w(R_INST, {4'h0, a, 4'h0, c});
    push_w(R_INSTWR, 32'd1);
  endtask

  // Reference: the full transfer list a command expands to.
  task automatic build_exp(input logic [3:0] op, input logic [11:0] a, input logic [31:0] wd);
    exp_q.delete();
    case (op)
      4'd0:  push_w(R_EN, 32'd1);
      4'd1:  push_w(R_EN, 32'd0);
      4'd2:  push_inst(a, C_ATT);
      4'd3:  push_inst(a, C_RES);
      4'd4:  begin push_inst(a, C_STAT); push_r(R_RDL); end
      4'd5:  begin push_inst(a, C_PC);   push_r(R_RDL); end
      4'd6:  begin push_inst(a, C_GRD);  push_r(R_RDL); end
      4'd7:  begin push_inst(a, C_CRD);  push_r(R_RDL); end
      4'd8, 4'd9: begin
        push_w(R_WDL, wd); push_w(R_WDWR, 32'd1);
        push_inst(a, (op == 4'd8) ? C_GWR : C_CWR);
      end
      4'd10: begin
        push_w(R_WDL, wd); push_w(R_WDWR, 32'd1);
        push_inst(a, C_IREG); push_inst(a, C_EXE);
      end
      default: ;
    endcase
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      waits[i] = 0;
      serr[i]  = 1'b0;
      rdat[i]  = $urandom;
    end
  endtask

  task automatic run_cmd(input string nm, input logic [3:0] op, input logic [11:0] a,
                         input logic [31:0] wd, input int hold);
    int          lat, cyc, ndone;
    bit          perr;
    logic [31:0] prd;
    build_exp(op, a, wd);
    lat = 0; perr = 1'b0; prd = '0; ndone = 0;
    if (exp_q.size() == 0) begin
      perr = 1'b1;
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        if (waits[k] >= TMO) begin lat += 1 + TMO; perr = 1'b1; break; end
        lat += 2 + waits[k];
        ndone++;
        if (serr[k]) begin perr = 1'b1; break; end
        if (!exp_q[k].write) prd = rdat[k];
      end
    end
    lat += 1;
    obs_q.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = wd;
    check({nm, " cmd_ready"}, bus.cmd_ready, 1);
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'($urandom); bus.cmd_addr = 12'($urandom); bus.cmd_wdata = $urandom;
    cyc = 0;
    do begin @(negedge pclk); cyc++; end while (!bus.rsp_valid && cyc < 5000);
    check({nm, " latency"}, cyc, lat);
    check({nm, " rsp_err"}, bus.rsp_err, perr);
    check({nm, " rsp_rdata"}, bus.rsp_rdata, prd);
    check({nm, " psel after"}, bus.psel, 0);
    check({nm, " n_xfer"}, obs_q.size(), ndone);
    for (int k = 0; k < ndone && k < obs_q.size(); k++) begin
      check($sformatf("%s x%0d addr", nm, k), {obs_q[k].strb, obs_q[k].write, obs_q[k].addr},
            {exp_q[k].strb, exp_q[k].write, exp_q[k].addr});
      check($sformatf("%s x%0d data", nm, k), obs_q[k].data, exp_q[k].data);
    end
    repeat (hold) @(negedge pclk);
    if (hold > 0) begin
      check({nm, " held valid"}, {bus.rsp_valid, bus.cmd_ready}, 2'b10);
      check({nm, " held data"}, {bus.rsp_err, bus.rsp_rdata}, {perr, prd});
    end
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    check({nm, " retire"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, " apb ctl"}, {bus.psel, bus.penable, bus.pwrite, bus.pstrb}, 0);
    check({nm, " apb addr/data"}, {bus.paddr, bus.pwdata}, 0);
    check({nm, " rsp"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
    check({nm, " cmd_ready"}, bus.cmd_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    preset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    clear_plan();
    repeat (3) @(posedge pclk);
    #1;
    check_reset_vals("reset");
    @(negedge pclk);
    preset = 1'b0;

    clear_plan();
    run_cmd("en", 4'd0, 12'h0, 32'h0, 0);
    clear_plan(); waits[1] = 1; rdat[2] = 32'h1234_5678;
    run_cmd("gpr_rd", 4'd6, 12'h005, 32'h0, 1);
    clear_plan();
    run_cmd("csr_wr", 4'd9, 12'h300, 32'h8, 0);
    clear_plan(); waits[5] = 5;
    run_cmd("exec", 4'd10, 12'h000, 32'h0010_0073, 2);
    clear_plan(); waits[0] = 2000;
    run_cmd("pc_rd tmo", 4'd5, 12'h000, 32'h0, 0);
    clear_plan(); waits[2] = TMO - 1;
    run_cmd("pc_rd maxwait", 4'd5, 12'h000, 32'h0, 0);
    clear_plan(); serr[0] = 1'b1;
    run_cmd("gpr_wr slverr", 4'd8, 12'h00A, 32'hDEAD_BEEF, 0);
    clear_plan(); serr[2] = 1'b1;
    run_cmd("csr_rd rd err", 4'd7, 12'h341, 32'h0, 0);
    clear_plan();
    run_cmd("illegal", 4'd15, 12'h0, 32'h0, 0);
    clear_plan();
    run_cmd("status hold", 4'd4, 12'h0, 32'h0, 10);

    // Reset in the middle of an ACCESS wait.
    clear_plan(); waits[0] = 50;
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd6; bus.cmd_addr = 12'h3;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 0;
    do begin @(negedge pclk); cyc++; end while (!bus.penable && cyc < 20);
    check("rst mid penable", bus.penable, 1);
    preset = 1'b1;
    @(posedge pclk); #1;
    check_reset_vals("rst mid");
    @(negedge pclk);
    preset = 1'b0;
    clear_plan();
    run_cmd("post rst", 4'd2, 12'h011, 32'h0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [3:0] op;
      clear_plan();
      for (int i = 0; i < 16; i++) begin
        waits[i] = $urandom_range(0, 3);
        serr[i]  = ($urandom_range(0, 11) == 0);
      end
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      run_cmd($sformatf("rnd%0d", t), op, 12'($urandom), $urandom, $urandom_range(0, 3));
    end

    check("apb setup single cycle", proto_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
